// File: rtl/mac_array.sv
// mac_array: three-stage pipelined multiply-accumulate array.
//
// A shared data tile of TAP signed samples is multiplied against NUM_FILT
// independent sets of TAP signed weights.  Per filter, the products are
// reduced and added into a saturating accumulator.  When a tile flagged
// as last reaches the accumulator, the finished sums are delivered in the
// output register and the accumulation restarts.
//
//   stage 1 : DW x DW signed products for every filter/tap (registered)
//   stage 2 : per-filter reduction of the TAP products, lossless (registered)
//   stage 3 : saturating accumulate; on last, load the output register
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   in_vld/in_rdy        tile handshake; in_last marks the final tile
//   din                  TAP x DW data tile, tap k at [DW*k +: DW]
//   weight               filter f, tap k at [DW*(TAP*f+k) +: DW]
//   out_vld/out_rdy      result handshake
//   sum                  filter f result at [ACC_W*f +: ACC_W]
//   sat                  per-filter saturation flag for the delivered result
//   tile_cnt             tiles in the delivered result (saturates at 16'hFFFF)
//
// Build option
//   MAC_ARRAY_RELU_EN    when defined, negative results are clamped to 0 as
//                        they are loaded into the output register.
module mac_array #(
  parameter int NUM_FILT = 40,
  parameter int TAP      = 36,
  parameter int DW       = 8,
  parameter int ACC_W    = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic                         in_last,
  input  logic [DW*TAP-1:0]            din,
  input  logic [DW*TAP*NUM_FILT-1:0]   weight,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [ACC_W*NUM_FILT-1:0]    sum,
  output logic [NUM_FILT-1:0]          sat,
  output logic [15:0]                  tile_cnt
);

  // Reduction width grows by clog2(TAP) so the tap sum can never overflow.
  localparam int SW = 2*DW + $clog2(TAP);
  // Stage-3 adder is one bit wider than either operand so overflow is visible.
  localparam int WW = ((ACC_W > SW) ? ACC_W : SW) + 1;

  typedef enum logic {IDLE, ACCUM} acc_state_e;

  logic en;

  logic s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [NUM_FILT-1:0][TAP-1:0][2*DW-1:0] prod_q, prod_d;
  logic [NUM_FILT-1:0][SW-1:0]            s2_sum_q, s2_sum_d;

  acc_state_e                     state_q, state_d;
  logic [NUM_FILT-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_FILT-1:0]            sat_acc_q, sat_acc_d;
  logic [15:0]                    cnt_q, cnt_d;

  logic                           out_vld_q, out_vld_d;
  logic [NUM_FILT-1:0][ACC_W-1:0] sum_q, sum_d;
  logic [NUM_FILT-1:0]            sat_q, sat_d;
  logic [15:0]                    tile_cnt_q, tile_cnt_d;

  logic [NUM_FILT-1:0][ACC_W-1:0] acc_base, acc_new;
  logic [NUM_FILT-1:0][WW-1:0]    wide_sum;
  logic [NUM_FILT-1:0]            ovf, sat_new;
  logic [15:0]                    cnt_base, cnt_new;

  function automatic logic signed [2*DW-1:0] sext_dw(input logic [DW-1:0] x);
    return {{DW{x[DW-1]}}, x};
  endfunction

  // A result that cannot leave stalls the entire pipe, including the accumulators.
  assign en       = !(out_vld_q && !out_rdy);
  assign in_rdy   = en;
  assign out_vld  = out_vld_q;
  assign sum      = sum_q;
  assign sat      = sat_q;
  assign tile_cnt = tile_cnt_q;

  // Stages 1 and 2: products and per-filter reduction.
  always_comb begin
    prod_d   = prod_q;
    s2_sum_d = s2_sum_q;
    if (en) begin
      for (int f = 0; f < NUM_FILT; f++) begin
        s2_sum_d[f] = '0;
        for (int k = 0; k < TAP; k++) begin
          prod_d[f][k] = sext_dw(din[DW*k +: DW]) * sext_dw(weight[DW*(TAP*f+k) +: DW]);
          s2_sum_d[f]  = s2_sum_d[f] + {{(SW-2*DW){prod_q[f][k][2*DW-1]}}, prod_q[f][k]};
        end
      end
    end
  end

  // Stage 3 arithmetic.  In IDLE the accumulator contents are ignored, so a
  // new accumulation always starts from zero.  Overflow shows up as the bits
  // above the ACC_W sign bit disagreeing with it.
  always_comb begin
    cnt_base = (state_q == ACCUM) ? cnt_q : 16'd0;
    cnt_new  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
    for (int f = 0; f < NUM_FILT; f++) begin
      acc_base[f] = (state_q == ACCUM) ? acc_q[f] : '0;
      wide_sum[f] = {{(WW-ACC_W){acc_base[f][ACC_W-1]}}, acc_base[f]}
                  + {{(WW-SW){s2_sum_q[f][SW-1]}}, s2_sum_q[f]};
      ovf[f]      = 1'b0;
      acc_new[f]  = wide_sum[f][ACC_W-1:0];
      if (!((&wide_sum[f][WW-1:ACC_W-1]) || !(|wide_sum[f][WW-1:ACC_W-1]))) begin
        ovf[f]     = 1'b1;
        acc_new[f] = wide_sum[f][WW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
      end
      sat_new[f] = ((state_q == ACCUM) && sat_acc_q[f]) || ovf[f];
    end
  end

  // Valid/last flags, accumulator state machine and output register.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s2_vld_d   = s2_vld_q;
    s2_last_d  = s2_last_q;
    state_d    = state_q;
    acc_d      = acc_q;
    sat_acc_d  = sat_acc_q;
    cnt_d      = cnt_q;
    out_vld_d  = out_vld_q;
    sum_d      = sum_q;
    sat_d      = sat_q;
    tile_cnt_d = tile_cnt_q;
    if (en) begin
      s1_vld_d  = in_vld;
      s1_last_d = in_last;
      s2_vld_d  = s1_vld_q;
      s2_last_d = s1_last_q;
      // With en high any held result is either absent or consumed this cycle.
      out_vld_d = 1'b0;
      if (s2_vld_q) begin
        if (s2_last_q) begin
          for (int f = 0; f < NUM_FILT; f++) begin
`ifdef MAC_ARRAY_RELU_EN
            sum_d[f] = acc_new[f][ACC_W-1] ? '0 : acc_new[f];
`else
            sum_d[f] = acc_new[f];
`endif
          end
          sat_d      = sat_new;
          tile_cnt_d = cnt_new;
          out_vld_d  = 1'b1;
          state_d    = IDLE;
          acc_d      = '0;
          sat_acc_d  = '0;
          cnt_d      = '0;
        end else begin
          state_d   = ACCUM;
          acc_d     = acc_new;
          sat_acc_d = sat_new;
          cnt_d     = cnt_new;
        end
      end
    end
  end

  // Datapath pipeline registers carry no reset; their valid flags gate them.
  always_ff @(posedge clk) begin
    prod_q   <= prod_d;
    s2_sum_q <= s2_sum_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      state_q    <= IDLE;
      acc_q      <= '0;
      sat_acc_q  <= '0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      sum_q      <= '0;
      sat_q      <= '0;
      tile_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_acc_q  <= sat_acc_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      sum_q      <= sum_d;
      sat_q      <= sat_d;
      tile_cnt_q <= tile_cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: scoreboard bench for mac_array with two filters and an
// 18-bit accumulator.  Directed tiles push hand-computed results into a
// queue; a monitor compares every presented result against the queue head
// and retires it when it is consumed.
module tb_mac_array;

  localparam int NF  = 2;
  localparam int TAP = 36;
  localparam int DW  = 8;
  localparam int AW  = 18;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic              in_last = 1'b0;
  logic [DW*TAP-1:0] din = '0;
  logic [DW*TAP*NF-1:0] weight = '0;
  logic              out_vld;
  logic              out_rdy = 1'b1;
  logic [AW*NF-1:0]  sum;
  logic [NF-1:0]     sat;
  logic [15:0]       tile_cnt;

  typedef struct {
    longint s0;
    longint s1;
    int     sat;
    int     cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mac_array #(.NUM_FILT(NF), .TAP(TAP), .DW(DW), .ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy), .in_last(in_last),
    .din(din), .weight(weight), .out_vld(out_vld), .out_rdy(out_rdy),
    .sum(sum), .sat(sat), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  function automatic longint relu(input longint v);
`ifdef MAC_ARRAY_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic pushExp(input longint s0, input longint s1, input int s, input int c);
    exp_t e;
    e.s0 = s0; e.s1 = s1; e.sat = s; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Presents one tile and returns one ns after the edge that accepted it,
  // leaving in_vld high so consecutive calls stream one tile per cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] w0, input logic [7:0] w1,
                               input logic last, output int waited);
    din     = {TAP{d}};
    weight  = {{TAP{w1}}, {TAP{w0}}};
    in_vld  = 1'b1;
    in_last = last;
    waited  = 0;
    while (!in_rdy && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL in_rdy_timeout: got in_rdy=0 for %0d cycles, expected acceptance", waited);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_vld  = 1'b0;
    in_last = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every cycle a result is presented it must match the queue head,
  // which also proves the outputs hold steady while stalled.
  always @(negedge clk) begin
    if (rstn && out_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got out_vld=1 sum0=%0d, expected no result", $signed(sum[AW-1:0]));
      end else begin
        checkOutput("sum_f0", $signed(sum[AW-1:0]), exp_q[0].s0);
        checkOutput("sum_f1", $signed(sum[2*AW-1:AW]), exp_q[0].s1);
        checkOutput("sat", longint'(sat), longint'(exp_q[0].sat));
        checkOutput("tile_cnt", longint'(tile_cnt), longint'(exp_q[0].cnt));
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int w;
    int k;

    // Reset values.
    rstn    = 1'b0;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_sum", longint'(sum), 0);
    checkOutput("rst_sat", longint'(sat), 0);
    checkOutput("rst_tile_cnt", longint'(tile_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single last tile of ones: 36 per filter, visible on the third edge.
    pushExp(36, 36, 0, 1);
    applyStimulus(8'd1, 8'd1, 8'd1, 1'b1, w);
    in_vld = 1'b0;
    checkOutput("latency_edge1", out_vld, 0);
    @(posedge clk); #1;
    checkOutput("latency_edge2", out_vld, 0);
    @(posedge clk); #1;
    checkOutput("latency_edge3", out_vld, 1);
    idle(3);

    // Four tiles of -2 x 3: -216 per tile, -864 total.
    pushExp(relu(-864), relu(-864), 0, 4);
    for (int i = 0; i < 4; i++) applyStimulus(8'hFE, 8'd3, 8'd3, (i == 3), w);
    idle(6);

    // Distinct filter weights: 5*2*36*2 = 720 and 5*(-1)*36*2 = -360.
    pushExp(720, relu(-360), 0, 2);
    for (int i = 0; i < 2; i++) applyStimulus(8'd5, 8'd2, 8'hFF, (i == 1), w);
    idle(6);

    // Saturation both ways: +/-580644 per tile exceeds the 18-bit range.
    pushExp(131071, relu(-131072), 3, 2);
    for (int i = 0; i < 2; i++) applyStimulus(8'd127, 8'd127, 8'h81, (i == 1), w);
    idle(6);

    // Back-pressure: first result held for 5 cycles, second waits behind it.
    out_rdy = 1'b0;
    pushExp(36, 36, 0, 1);
    applyStimulus(8'd1, 8'd1, 8'd1, 1'b1, w);
    pushExp(72, 72, 0, 1);
    applyStimulus(8'd2, 8'd1, 8'd1, 1'b1, w);
    in_vld = 1'b0;
    k = 0;
    while (!out_vld && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL stall_result_timeout: got out_vld=0, expected 1");
    end
    repeat (5) begin
      checkOutput("stall_in_rdy", in_rdy, 0);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    idle(5);

    // Reset after two of three tiles discards the partial sum.
    for (int i = 0; i < 2; i++) applyStimulus(8'd1, 8'd1, 8'd1, 1'b0, w);
    in_vld = 1'b0;
    rstn   = 1'b0;
    #2;
    checkOutput("midrst_out_vld", out_vld, 0);
    checkOutput("midrst_tile_cnt", longint'(tile_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    pushExp(72, 72, 0, 1);
    applyStimulus(8'd2, 8'd1, 8'd1, 1'b1, w);
    idle(6);

    // Streaming single-tile results, one per cycle, in_rdy never drops.
    for (int i = 1; i <= 6; i++) begin
      pushExp(36 * i, 36 * i, 0, 1);
      applyStimulus(8'(i), 8'd1, 8'd1, 1'b1, w);
      checkOutput("stream_wait_cycles", w, 0);
    end
    in_vld = 1'b0;

    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("pending_results", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
